pipeline_id_ex_stage: RTL and testbench
=======================================

Name: pipeline_id_ex_stage

Overview:
ID/EX boundary of the 5-stage RISC-V pipeline. Latches the decode bundle produced by the ID stage and presents it to EX. Contains the data-hazard (RAW) stall detector, which uses the Rs1/Rs2 addresses and used flags from ID, and the control-hazard flush logic driven by EX redirect. No forwarding exists in this design, so conflicts resolve by stalling.

Parameters:
NOP_INST, 32'h00000013, instruction word placed in a bubble (addi x0,x0,0)
WB_STALL, 0, 1 = also stall on WB-stage conflicts (0 when the RF writes on the falling edge)
CNT_W, 32, width of the saturating performance counters

Ports:
clk_IDEX  in  1  clock; all state updates on the rising edge
rst_IDEX  in  1  reset, synchronous, active-high
valid_in  in  1  ID holds a real instruction
PC_in / inst_in  in  32/32  PC and instruction word from ID
Rd_addr_in / Rs1_addr_in / Rs2_addr_in  in  5 each  register addresses from ID
Rs1_used / Rs2_used  in  1 each  instruction reads rs1/rs2
Rs1_data_in / Rs2_data_in / Imm_in  in  32 each  operands and immediate
ALUSrc_B_in / Branch_in / BranchN_in / Jump_in / MemRW_in / RegWrite_in  in  1 each  control
ALU_control_in / MemtoReg_in  in  4/2  control
RegWrite_MEM / Rd_addr_MEM  in  1/5  destination info of the instruction in MEM
RegWrite_WB / Rd_addr_WB  in  1/5  destination info of the instruction in WB
redirect_EX  in  1  branch taken or jump resolved in EX
*_out (one per registered input above, valid_out included)  out  same widths  EX-side copy of each input
stall_PC / stall_IFID  out  1 each  hold the PC and the IF/ID register
flush_IFID  out  1  turn the IF/ID contents into a bubble
stall_cnt / flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_IDEX=1 at an edge):
  - All *_out go to 0, except inst_out=NOP_INST. valid_out=0.
  - Both counters go to 0.
  - A stall in progress is aborted. The next cycle evaluates inputs fresh.
- Hazard, evaluated combinationally in the current cycle:
  - hz1 = valid_in & Rs1_used & Rs1_addr_in!=0 & (EXhit1 | MEMhit1 | (WB_STALL & WBhit1)).
  - EXhit1 = valid_out & RegWrite_out & Rd_addr_out==Rs1_addr_in.
  - MEMhit1 = RegWrite_MEM & Rd_addr_MEM==Rs1_addr_in.
  - WBhit1 is defined the same way using the WB inputs.
  - hz2 is defined identically for rs2. hazard = hz1 | hz2.
- Next state at each edge, highest priority first:
  1. redirect_EX: load a bubble. flush_IFID=1, stall_PC=stall_IFID=0. flush_cnt++.
  2. hazard: load a bubble. stall_PC=stall_IFID=1, flush_IFID=0. stall_cnt++.
  3. Otherwise: load all inputs, with valid_out=valid_in. No stall and no flush.
- Bubble contents:
  - valid_out=0, inst_out=NOP_INST.
  - RegWrite, MemRW, Branch, BranchN and Jump outputs = 0.
  - All other fields = 0.
- stall_PC, stall_IFID and flush_IFID are combinational. They are forced to 0 while rst_IDEX=1.
- Latency: 1 cycle from ID inputs to *_out.
- Stall length: a dependent instruction immediately behind its producer stalls 2 cycles (EX hit, then MEM hit); with WB_STALL=1 it stalls 3.
- Writes to x0 never cause a stall.
- Counters saturate at all-ones; they do not wrap.

Decomposition:
- Shared package pipeline_pkg holds:
  - NOP_INST constant;
  - ALU_control and MemtoReg encodings;
  - a typedef idex_bundle_t grouping every registered field.
- One sub-module, hazard_detect: purely combinational; produces hazard from the addresses, used flags and stage destinations.
- The register, priority mux and counters stay in the top module.

Test Plan:
1. add x1,x2,x3 then add x4,x1,x5 back-to-back -> stall_PC=1 for exactly 2 cycles; on the 3rd edge the second add appears with valid_out=1; stall_cnt=2.
2. addi x0,x0,5 then add x4,x0,x0 -> no stall; consumer reaches EX on the next edge.
3. Producer in WB only (RegWrite_WB=1, Rd_addr_WB=7), ID reads x7 -> WB_STALL=0: no stall; WB_STALL=1: one stall cycle.
4. Hazard and redirect_EX in the same cycle -> flush_IFID=1, stall_PC=0, bubble loaded (inst_out=32'h00000013, valid_out=0); flush_cnt=1, stall_cnt unchanged.
5. rst_IDEX asserted during the second stall cycle -> after the edge all outputs are reset values; with the producer gone, ID advances the next cycle.
6. CNT_W=4 with 20 consecutive hazard cycles -> stall_cnt holds at 4'hF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants, control encodings and the ID/EX bundle type
package pipeline_pkg;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;
  typedef enum logic [1:0] {
    M2R_ALU = 2'd0,
    M2R_MEM = 2'd1,
    M2R_PC4 = 2'd2,
    M2R_IMM = 2'd3
  } memtoreg_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        alusrc_b;
    logic        branch;
    logic        branchn;
    logic        jump;
    logic        memrw;
    logic        regwrite;
    logic [3:0]  alu_ctrl;
    logic [1:0]  memtoreg;
  } idex_bundle_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: RAW conflict between the ID sources and in-flight destinations
module hazard_detect #(
  parameter bit WB_STALL = 1'b0
) (
  input  logic       valid_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic       ex_valid_i,
  input  logic       ex_rw_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_rw_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_rw_i,
  input  logic [4:0] wb_rd_i,
  output logic       hazard_o
);
  // x0 is never a real dependency, so it is excluded before any stage match
  function automatic logic hit(input logic [4:0] rs);
    return (rs != 5'd0) &&
           ((ex_valid_i && ex_rw_i && ex_rd_i == rs) ||
            (mem_rw_i && mem_rd_i == rs) ||
            (WB_STALL && wb_rw_i && wb_rd_i == rs));
  endfunction
  assign hazard_o = valid_i && ((rs1_used_i && hit(rs1_i)) || (rs2_used_i && hit(rs2_i)));
endmodule

// File: rtl/pipeline_id_ex_stage.sv
// pipeline_id_ex_stage: ID/EX register with RAW stall, redirect flush and perf counters
module pipeline_id_ex_stage
  import pipeline_pkg::idex_bundle_t;
#(
  parameter logic [31:0] NOP_INST = pipeline_pkg::NOP_INST,
  parameter bit          WB_STALL = 1'b0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_IDEX,
  input  logic             rst_IDEX,
  input  logic             valid_in,
  input  logic [31:0]      PC_in,
  input  logic [31:0]      inst_in,
  input  logic [4:0]       Rd_addr_in,
  input  logic [4:0]       Rs1_addr_in,
  input  logic [4:0]       Rs2_addr_in,
  input  logic             Rs1_used,
  input  logic             Rs2_used,
  input  logic [31:0]      Rs1_data_in,
  input  logic [31:0]      Rs2_data_in,
  input  logic [31:0]      Imm_in,
  input  logic             ALUSrc_B_in,
  input  logic             Branch_in,
  input  logic             BranchN_in,
  input  logic             Jump_in,
  input  logic             MemRW_in,
  input  logic             RegWrite_in,
  input  logic [3:0]       ALU_control_in,
  input  logic [1:0]       MemtoReg_in,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       Rd_addr_MEM,
  input  logic             RegWrite_WB,
  input  logic [4:0]       Rd_addr_WB,
  input  logic             redirect_EX,
  output logic             valid_out,
  output logic [31:0]      PC_out,
  output logic [31:0]      inst_out,
  output logic [4:0]       Rd_addr_out,
  output logic [4:0]       Rs1_addr_out,
  output logic [4:0]       Rs2_addr_out,
  output logic             Rs1_used_out,
  output logic             Rs2_used_out,
  output logic [31:0]      Rs1_data_out,
  output logic [31:0]      Rs2_data_out,
  output logic [31:0]      Imm_out,
  output logic             ALUSrc_B_out,
  output logic             Branch_out,
  output logic             BranchN_out,
  output logic             Jump_out,
  output logic             MemRW_out,
  output logic             RegWrite_out,
  output logic [3:0]       ALU_control_out,
  output logic [1:0]       MemtoReg_out,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             flush_IFID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  idex_bundle_t in_b, bub_b, bundle_d, bundle_q;
  logic hazard;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  hazard_detect #(.WB_STALL(WB_STALL)) u_hazard (
    .valid_i    (valid_in),
    .rs1_i      (Rs1_addr_in),
    .rs2_i      (Rs2_addr_in),
    .rs1_used_i (Rs1_used),
    .rs2_used_i (Rs2_used),
    .ex_valid_i (bundle_q.valid),
    .ex_rw_i    (bundle_q.regwrite),
    .ex_rd_i    (bundle_q.rd),
    .mem_rw_i   (RegWrite_MEM),
    .mem_rd_i   (Rd_addr_MEM),
    .wb_rw_i    (RegWrite_WB),
    .wb_rd_i    (Rd_addr_WB),
    .hazard_o   (hazard)
  );

  assign in_b = '{valid: valid_in, pc: PC_in, inst: inst_in, rd: Rd_addr_in,
                  rs1: Rs1_addr_in, rs2: Rs2_addr_in, rs1_used: Rs1_used, rs2_used: Rs2_used,
                  rs1_data: Rs1_data_in, rs2_data: Rs2_data_in, imm: Imm_in,
                  alusrc_b: ALUSrc_B_in, branch: Branch_in, branchn: BranchN_in,
                  jump: Jump_in, memrw: MemRW_in, regwrite: RegWrite_in,
                  alu_ctrl: ALU_control_in, memtoreg: MemtoReg_in};

  // Redirect outranks the hazard: the stalled instruction is on the wrong path anyway
  always_comb begin
    bub_b = '0;
    bub_b.inst = NOP_INST;
    bundle_d = (redirect_EX || hazard) ? bub_b : in_b;
    stall_cnt_d = (hazard && !redirect_EX && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (redirect_EX && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // Reset state equals a bubble, so a stall in progress is simply dropped
  always_ff @(posedge clk_IDEX) begin
    if (rst_IDEX) begin
      bundle_q <= bub_b;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      bundle_q <= bundle_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_PC   = !rst_IDEX && !redirect_EX && hazard;
  assign stall_IFID = stall_PC;
  assign flush_IFID = !rst_IDEX && redirect_EX;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  assign valid_out       = bundle_q.valid;
  assign PC_out          = bundle_q.pc;
  assign inst_out        = bundle_q.inst;
  assign Rd_addr_out     = bundle_q.rd;
  assign Rs1_addr_out    = bundle_q.rs1;
  assign Rs2_addr_out    = bundle_q.rs2;
  assign Rs1_used_out    = bundle_q.rs1_used;
  assign Rs2_used_out    = bundle_q.rs2_used;
  assign Rs1_data_out    = bundle_q.rs1_data;
  assign Rs2_data_out    = bundle_q.rs2_data;
  assign Imm_out         = bundle_q.imm;
  assign ALUSrc_B_out    = bundle_q.alusrc_b;
  assign Branch_out      = bundle_q.branch;
  assign BranchN_out     = bundle_q.branchn;
  assign Jump_out        = bundle_q.jump;
  assign MemRW_out       = bundle_q.memrw;
  assign RegWrite_out    = bundle_q.regwrite;
  assign ALU_control_out = bundle_q.alu_ctrl;
  assign MemtoReg_out    = bundle_q.memtoreg;
endmodule

// File: tb/tb_pipeline_id_ex_stage.sv
// tb_pipeline_id_ex_stage: directed vector table plus randomized run against a pending-write model
module tb_pipeline_id_ex_stage;
  localparam logic [31:0] N  = 32'h00000013;
  localparam logic [31:0] IA = 32'h003100B3;
  localparam logic [31:0] IB = 32'h00508233;
  localparam logic [31:0] IC = 32'h00000233;
  localparam logic [31:0] ID = 32'h00038433;
  localparam logic [31:0] II = 32'h00500013;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, inst;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2;
    logic [31:0] d1, d2, imm;
    logic        alusrc, br, brn, j, mrw, rw;
    logic [3:0]  aluc;
    logic [1:0]  m2r;
  } idv_t;

  typedef struct {
    bit rst, redir, v;
    bit [4:0] rd, rs1, rs2;
    bit u1, u2, rw;
    bit [31:0] inst;
    bit mrw;
    bit [4:0] mrd;
    bit wrw;
    bit [4:0] wrd;
    bit st0, st1, fl, vo;
    bit [31:0] io;
    int sc, fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst, redir, mrw, wrw;
  logic [4:0] mrd, wrd;
  idv_t id;
  idv_t act [2];
  logic sp [2], si [2], fl [2];
  logic [31:0] sca [2], fca [2];

  idv_t m_ex [2];
  longint m_sc [2], m_fc [2];
  bit ehz [2];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int CW = k ? 4 : 32;
    idv_t a;
    logic [CW-1:0] sc, fc;
    pipeline_id_ex_stage #(.WB_STALL(k == 1), .CNT_W(CW)) dut (
      .clk_IDEX(clk), .rst_IDEX(rst), .valid_in(id.v), .PC_in(id.pc), .inst_in(id.inst),
      .Rd_addr_in(id.rd), .Rs1_addr_in(id.rs1), .Rs2_addr_in(id.rs2),
      .Rs1_used(id.u1), .Rs2_used(id.u2), .Rs1_data_in(id.d1), .Rs2_data_in(id.d2),
      .Imm_in(id.imm), .ALUSrc_B_in(id.alusrc), .Branch_in(id.br), .BranchN_in(id.brn),
      .Jump_in(id.j), .MemRW_in(id.mrw), .RegWrite_in(id.rw), .ALU_control_in(id.aluc),
      .MemtoReg_in(id.m2r), .RegWrite_MEM(mrw), .Rd_addr_MEM(mrd), .RegWrite_WB(wrw),
      .Rd_addr_WB(wrd), .redirect_EX(redir),
      .valid_out(a.v), .PC_out(a.pc), .inst_out(a.inst), .Rd_addr_out(a.rd),
      .Rs1_addr_out(a.rs1), .Rs2_addr_out(a.rs2), .Rs1_used_out(a.u1), .Rs2_used_out(a.u2),
      .Rs1_data_out(a.d1), .Rs2_data_out(a.d2), .Imm_out(a.imm), .ALUSrc_B_out(a.alusrc),
      .Branch_out(a.br), .BranchN_out(a.brn), .Jump_out(a.j), .MemRW_out(a.mrw),
      .RegWrite_out(a.rw), .ALU_control_out(a.aluc), .MemtoReg_out(a.m2r),
      .stall_PC(sp[k]), .stall_IFID(si[k]), .flush_IFID(fl[k]), .stall_cnt(sc), .flush_cnt(fc)
    );
    assign act[k] = a;
    assign sca[k] = 32'(sc);
    assign fca[k] = 32'(fc);
  end

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  function automatic idv_t bubble();
    idv_t b = '0;
    b.inst = N;
    return b;
  endfunction

  // Set of registers some older instruction is still going to write
  function automatic bit m_hz(input int k);
    logic [31:0] pend = '0;
    if (m_ex[k].v && m_ex[k].rw) pend[m_ex[k].rd] = 1'b1;
    if (mrw) pend[mrd] = 1'b1;
    if (k == 1 && wrw) pend[wrd] = 1'b1;
    pend[0] = 1'b0;
    return id.v && ((id.u1 && pend[id.rs1]) || (id.u2 && pend[id.rs2]));
  endfunction

  function automatic logic [31:0] sat(input longint c, input int w);
    longint mx = (longint'(1) << w) - 1;
    return 32'(c > mx ? mx : c);
  endfunction

  task automatic tick(input bit tchk, input vec_t r);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ehz[k] = m_hz(k);
      chk($sformatf("comb%0d", k), {sp[k], si[k], fl[k]},
          {!rst && !redir && ehz[k], !rst && !redir && ehz[k], !rst && redir});
    end
    if (tchk) begin
      chk("tbl_stall0", sp[0], r.st0);
      chk("tbl_stall1", sp[1], r.st1);
      chk("tbl_flush", fl[0], r.fl);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ex[k] = bubble();
        m_sc[k] = 0;
        m_fc[k] = 0;
      end else if (redir) begin
        m_ex[k] = bubble();
        m_fc[k]++;
      end else if (ehz[k]) begin
        m_ex[k] = bubble();
        m_sc[k]++;
      end else m_ex[k] = id;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bundle%0d", k), act[k], m_ex[k]);
      chk($sformatf("stall_cnt%0d", k), sca[k], sat(m_sc[k], k ? 4 : 32));
      chk($sformatf("flush_cnt%0d", k), fca[k], sat(m_fc[k], k ? 4 : 32));
    end
    if (tchk) begin
      chk("tbl_valid_out", act[0].v, r.vo);
      chk("tbl_inst_out", act[0].inst, r.io);
      chk("tbl_stall_cnt", sca[0], r.sc);
      chk("tbl_flush_cnt", fca[0], r.fc);
    end
  endtask

  task automatic apply(input vec_t r, input int i);
    id = '0;
    id.v = r.v; id.rd = r.rd; id.rs1 = r.rs1; id.rs2 = r.rs2;
    id.u1 = r.u1; id.u2 = r.u2; id.rw = r.rw; id.inst = r.inst;
    id.pc = 32'(i * 4);
    rst = r.rst; redir = r.redir; mrw = r.mrw; mrd = r.mrd; wrw = r.wrw; wrd = r.wrd;
  endtask

  vec_t tbl [16];

  initial begin
    // rst redir v rd rs1 rs2 u1 u2 rw inst mrw mrd wrw wrd | st0 st1 fl vo io sc fc
    tbl[0]  = '{1,0,0,0,0,0,0,0,0,N, 0,0,0,0, 0,0,0,0,N, 0,0};
    tbl[1]  = '{0,0,1,1,2,3,1,1,1,IA,0,0,0,0, 0,0,0,1,IA,0,0};
    tbl[2]  = '{0,0,1,4,1,5,1,1,1,IB,0,0,0,0, 1,1,0,0,N, 1,0};
    tbl[3]  = '{0,0,1,4,1,5,1,1,1,IB,1,1,0,0, 1,1,0,0,N, 2,0};
    tbl[4]  = '{0,0,1,4,1,5,1,1,1,IB,0,0,1,1, 0,1,0,1,IB,2,0};
    tbl[5]  = '{0,0,0,0,0,0,0,0,0,N, 0,0,0,0, 0,0,0,0,N, 2,0};
    tbl[6]  = '{0,0,1,0,0,0,1,0,1,II,0,0,0,0, 0,0,0,1,II,2,0};
    tbl[7]  = '{0,0,1,4,0,0,1,1,1,IC,0,0,0,0, 0,0,0,1,IC,2,0};
    tbl[8]  = '{0,0,1,8,7,0,1,1,1,ID,0,0,1,7, 0,1,0,1,ID,2,0};
    tbl[9]  = '{0,0,0,0,0,0,0,0,0,N, 0,0,0,0, 0,0,0,0,N, 2,0};
    tbl[10] = '{0,0,1,1,2,3,1,1,1,IA,0,0,0,0, 0,0,0,1,IA,2,0};
    tbl[11] = '{0,1,1,4,1,5,1,1,1,IB,0,0,0,0, 0,0,1,0,N, 2,1};
    tbl[12] = '{0,0,1,1,2,3,1,1,1,IA,0,0,0,0, 0,0,0,1,IA,2,1};
    tbl[13] = '{0,0,1,4,1,5,1,1,1,IB,0,0,0,0, 1,1,0,0,N, 3,1};
    tbl[14] = '{1,0,1,4,1,5,1,1,1,IB,1,1,0,0, 0,0,0,0,N, 0,0};
    tbl[15] = '{0,0,1,4,1,5,1,1,1,IB,0,0,1,1, 0,1,0,1,IB,0,0};
    for (int k = 0; k < 2; k++) m_ex[k] = bubble();
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], i);
      tick(1'b1, tbl[i]);
    end
    // 20 back-to-back hazard cycles: the 4-bit counter must stick at all-ones
    for (int i = 0; i < 20; i++) begin
      apply('{0,0,1,4,1,5,1,1,1,IB,1,1,0,0, 0,0,0,0,N, 0,0}, 16 + i);
      tick(1'b0, tbl[0]);
    end
    chk("sat_cnt32", sca[0], 32'd20);
    chk("sat_cnt4", sca[1], 32'hF);
    for (int i = 0; i < 3000; i++) begin
      id.v = $urandom_range(0, 3) != 0;
      id.pc = $urandom; id.inst = $urandom;
      id.rd = 5'($urandom_range(0, 3)); id.rs1 = 5'($urandom_range(0, 3)); id.rs2 = 5'($urandom_range(0, 3));
      id.u1 = 1'($urandom); id.u2 = 1'($urandom);
      id.d1 = $urandom; id.d2 = $urandom; id.imm = $urandom;
      {id.alusrc, id.br, id.brn, id.j, id.mrw, id.rw, id.aluc, id.m2r} = 12'($urandom);
      mrw = 1'($urandom); mrd = 5'($urandom_range(0, 3));
      wrw = 1'($urandom); wrd = 5'($urandom_range(0, 3));
      rst = $urandom_range(0, 63) == 0;
      redir = $urandom_range(0, 7) == 0;
      tick(1'b0, tbl[0]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
